// File: rtl/halflife_pkg.sv
// Shared types for the half-life timer: run-state encoding and step-mode codes.
package halflife_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_DECAY = 2'b11;

endpackage

// File: rtl/halflife_prescaler.sv
// Step prescaler: counts enabled cycles and ticks once every max(period,1) cycles.
module halflife_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] period_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] last;

  // A period below the current count lets the counter wrap through all-ones.
  assign last   = (period_i == '0) ? '0 : period_i - PRESCALE_W'(1);
  assign tick_o = enable_i && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = tick_o ? '0 : cnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/halflife_timer.sv
// Loadable WIDTH-bit timer with hold/up/down/decay stepping, run/done FSM,
// halving counter and one-cycle completion pulse.
module halflife_timer
  import halflife_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic [3:0]            halvings,
  output logic                  running,
  output logic                  done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, step_val;
  logic [3:0]       halv_q, halv_d;
  logic             done_q, done_d;
  logic             presc_clr, presc_en, tick;

  function automatic logic is_terminal(input logic [1:0] m, input logic [WIDTH-1:0] v);
    case (m)
      MODE_UP:               return v == '1;
      MODE_DOWN, MODE_DECAY: return v == '0;
      default:               return 1'b0;
    endcase
  endfunction

  halflife_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (presc_clr),
    .enable_i (presc_en),
    .period_i (period),
    .tick_o   (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    halv_d    = halv_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;
    presc_en  = 1'b0;
    step_val  = count_q;
    if (load) begin
      count_d   = load_val;
      halv_d    = '0;
      presc_clr = 1'b1;
      state_d   = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (start && state_q != RUN) begin
      presc_clr = (state_q == DONE);
      if (is_terminal(mode, count_q)) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      presc_en = 1'b1;
      if (tick) begin
        // A count that became terminal via a mode change stops without stepping.
        if (is_terminal(mode, count_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          case (mode)
            MODE_UP:    step_val = count_q + WIDTH'(1);
            MODE_DOWN:  step_val = count_q - WIDTH'(1);
            MODE_DECAY: begin
              step_val = count_q >> 1;
              if (halv_q != 4'hF) halv_d = halv_q + 4'd1;
            end
            default:    step_val = count_q;
          endcase
          count_d = step_val;
          if (is_terminal(mode, step_val)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      halv_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      halv_q  <= halv_d;
      done_q  <= done_d;
    end
  end

  assign count    = count_q;
  assign halvings = halv_q;
  assign running  = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_halflife_timer.sv
// Scenario bench for halflife_timer: expected step events are queued per scenario
// and consumed as the count changes.
module tb_halflife_timer;

  logic        clk = 1'b0;
  logic        reset, load, start, stop;
  logic [7:0]  load_val;
  logic [1:0]  mode;
  logic [15:0] period;
  logic [7:0]  count;
  logic [3:0]  halvings;
  logic        running, done;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic [3:0] halv;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   done_n = 0;
  int   done_at = -1;

  halflife_timer #(
    .WIDTH(8),
    .PRESCALE_W(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .period   (period),
    .start    (start),
    .stop     (stop),
    .count    (count),
    .halvings (halvings),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_n++;
      done_at = cyc;
    end
  endtask

  task automatic push(input int c, input logic [7:0] v, input logic [3:0] h);
    exp_t e;
    e.cyc = c; e.cnt = v; e.halv = h;
    sb.push_back(e);
  endtask

  // Consume queued step events as the count changes, for a bounded number of cycles.
  task automatic drain(input int budget);
    logic [7:0] prev;
    exp_t e;
    prev = count;
    for (int i = 0; i < budget; i++) begin
      clk1();
      if (count !== prev) begin
        prev = count;
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_step: count=%0d at cyc %0d, no step expected", count, cyc);
        end else begin
          e = sb.pop_front();
          if (count !== e.cnt || halvings !== e.halv || cyc !== e.cyc)
            $display("FAIL step: got count=%0d halv=%0d cyc=%0d, expected count=%0d halv=%0d cyc=%0d",
                     count, halvings, cyc, e.cnt, e.halv, e.cyc);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (sb.size() != 0) begin
      $display("FAIL missing_steps: %0d expected steps not seen, expected 0 outstanding", sb.size());
      sb.delete();
    end else pass_cnt++;
  endtask

  task automatic do_load(input logic [7:0] v, input logic [1:0] m, input logic [15:0] p);
    load_val = v; mode = m; period = p; load = 1'b1;
    clk1();
    load = 1'b0;
    total_cnt++;
    if (count !== v || halvings !== 4'd0 || running !== 1'b0)
      $display("FAIL load: got count=%0d halv=%0d run=%0b, expected count=%0d halv=0 run=0",
               count, halvings, running, v);
    else pass_cnt++;
  endtask

  task automatic do_start();
    start = 1'b1;
    clk1();
    start = 1'b0;
    cyc = 0;
    done_n = 0;
    done_at = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; start = 1'b1; stop = 1'b0;
    load_val = 8'd77; mode = 2'b01; period = 16'd1;
    clk1();
    clk1();
    reset = 1'b0; load = 1'b0; start = 1'b0;
    total_cnt++;
    if (count !== 8'd0 || halvings !== 4'd0 || running !== 1'b0 || done !== 1'b0)
      $display("FAIL reset: got count=%0d halv=%0d run=%0b done=%0b, expected 0/0/0/0",
               count, halvings, running, done);
    else pass_cnt++;
  endtask

  task automatic test_decay();
    do_load(8'd200, 2'b11, 16'd3);
    do_start();
    total_cnt++;
    if (running !== 1'b1) $display("FAIL decay_running: got %0b expected 1", running);
    else pass_cnt++;
    for (int i = 1; i <= 8; i++) push(3 * i, 8'(200 >> i), 4'(i));
    drain(30);
    total_cnt++;
    if (done_n !== 1 || done_at !== 24 || running !== 1'b0 || halvings !== 4'd8)
      $display("FAIL decay_done: got pulses=%0d at=%0d run=%0b halv=%0d, expected 1/24/0/8",
               done_n, done_at, running, halvings);
    else pass_cnt++;
  endtask

  task automatic test_up_terminal();
    do_load(8'd253, 2'b01, 16'd0);
    do_start();
    push(1, 8'd254, 4'd0);
    push(2, 8'd255, 4'd0);
    drain(6);
    total_cnt++;
    if (done_n !== 1 || done_at !== 2 || count !== 8'd255 || running !== 1'b0)
      $display("FAIL up_done: got pulses=%0d at=%0d count=%0d run=%0b, expected 1/2/255/0",
               done_n, done_at, count, running);
    else pass_cnt++;
    start = 1'b1;
    clk1();
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b1 || count !== 8'd255 || running !== 1'b0)
      $display("FAIL up_restart: got done=%0b count=%0d run=%0b, expected 1/255/0", done, count, running);
    else pass_cnt++;
    clk1();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL up_pulse_width: got done=%0b expected 0", done);
    else pass_cnt++;
  endtask

  task automatic test_stop_start();
    do_load(8'd5, 2'b10, 16'd4);
    do_start();
    push(4, 8'd4, 4'd0);
    drain(6);
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    total_cnt++;
    if (running !== 1'b0 || count !== 8'd4)
      $display("FAIL stop: got run=%0b count=%0d, expected 0/4", running, count);
    else pass_cnt++;
    drain(5);
    do_start();
    push(2, 8'd3, 4'd0);
    push(6, 8'd2, 4'd0);
    drain(7);
  endtask

  task automatic test_back_to_back();
    do_load(8'd100, 2'b01, 16'd2);
    do_start();
    push(2, 8'd101, 4'd0);
    push(4, 8'd102, 4'd0);
    drain(5);
    done_n = 0;
    load_val = 8'd42; load = 1'b1; start = 1'b1;
    clk1();
    load = 1'b0; start = 1'b0;
    total_cnt++;
    if (count !== 8'd42 || running !== 1'b0 || done !== 1'b0)
      $display("FAIL load_start: got count=%0d run=%0b done=%0b, expected 42/0/0", count, running, done);
    else pass_cnt++;
    drain(4);
    total_cnt++;
    if (count !== 8'd42 || done_n !== 0 || running !== 1'b0)
      $display("FAIL load_start_idle: got count=%0d pulses=%0d run=%0b, expected 42/0/0",
               count, done_n, running);
    else pass_cnt++;
  endtask

  task automatic test_mode_switch();
    do_load(8'd8, 2'b01, 16'd2);
    do_start();
    push(2, 8'd9, 4'd0);
    push(4, 8'd10, 4'd0);
    drain(4);
    mode = 2'b11;
    push(6, 8'd5, 4'd1);
    drain(2);
    total_cnt++;
    if (running !== 1'b1 || halvings !== 4'd1)
      $display("FAIL mode_switch: got run=%0b halv=%0d, expected 1/1", running, halvings);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_decay();
    test_up_terminal();
    test_stop_start();
    test_back_to_back();
    test_mode_switch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
